// File: rtl/sprite_compositor.sv
// N-slot sprite compositor: three-band background plus prioritised RGB565 sprites
// over a two-stage pipeline, with per-frame shadowed sprite registers and frame animation.
package sprite_compositor_pkg;
  typedef struct packed {
    logic [1:0] nfm1;
    logic       anim_en;
    logic       hflip;
    logic       en;
  } spr_ctrl_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    spr_ctrl_t  ctrl;
  } spr_regs_t;
endpackage

module sprite_lane
  import sprite_compositor_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_x,
  input  logic              wr_y,
  input  logic              wr_ctrl,
  input  logic [9:0]        wdata,
  input  logic              frame_latch,
  input  logic              tick,
  input  logic [10:0]       px,
  input  logic [9:0]        py,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              hit_q
);
  localparam int SW = $clog2(SIZE);

  spr_regs_t     shd, act;
  logic [1:0]    frame;
  logic          hit, hit_s1;
  logic [SW-1:0] col, row;
  logic [ADDR_W-1:0] addr_nxt;

  // Offsets only need the low SW bits: a hit guarantees the difference is < SIZE.
  always_comb begin
    hit = act.ctrl.en
       && px >= {1'b0, act.x} && px < {1'b0, act.x} + 11'(SIZE)
       && {1'b0, py} >= {1'b0, act.y} && {1'b0, py} < {1'b0, act.y} + 11'(SIZE);
    col = px[SW-1:0] - act.x[SW-1:0];
    if (act.ctrl.hflip) col = ~col;
    row = py[SW-1:0] - act.y[SW-1:0];
    addr_nxt = ADDR_W'({frame, row, col});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shd      <= '0;
      act      <= '0;
      frame    <= '0;
      rom_addr <= '0;
      hit_s1   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      if (wr_x)    shd.x    <= wdata;
      if (wr_y)    shd.y    <= wdata;
      if (wr_ctrl) shd.ctrl <= spr_ctrl_t'(wdata[4:0]);
      if (frame_latch) act <= shd;
      // Wrap also catches a frame left beyond a freshly shrunk nframes.
      if (!act.ctrl.anim_en) frame <= '0;
      else if (tick)         frame <= (frame >= act.ctrl.nfm1) ? 2'd0 : frame + 2'd1;
      if (hit) rom_addr <= addr_nxt;
      hit_s1 <= hit;
      hit_q  <= hit_s1;
    end
  end
endmodule

module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int N_SPRITES = 8,
  parameter int SIZE      = 32,
  parameter int X_SHIFT   = 1,
  parameter int V_ACTIVE  = 480,
  parameter int ADDR_W    = $clog2(4*SIZE*SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [8:0]                  address,
  input  logic [31:0]                 writedata,
  input  logic [10:0]                 hcount,
  input  logic [9:0]                  vcount,
  input  logic                        blank_n_in,
  output logic [N_SPRITES*ADDR_W-1:0] rom_addr,
  input  logic [N_SPRITES*16-1:0]     rom_data,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        blank_n_out
);
  localparam int STAGES = 2;

  logic        wr, spr_wr, frame_latch, tick;
  logic [10:0] px;
  logic [23:0] sky, ground, line_c, bg0, bg_s1, bg_s2, pix;
  logic [9:0]  horizon;
  logic [23:0] anim_period, tick_cnt;
  logic [STAGES:1] vld_pipe;
  logic [N_SPRITES-1:0]             hit_s2;
  logic [N_SPRITES-1:0][ADDR_W-1:0] addr_arr;
  logic [N_SPRITES-1:0][15:0]       rd;
  logic        unused_wdata;

  assign wr          = chipselect && write;
  assign spr_wr      = wr && !address[8] && (address[7:2] < 6'(N_SPRITES));
  assign frame_latch = (hcount == 11'd0) && (vcount == 10'(V_ACTIVE));
  assign px          = hcount >> X_SHIFT;
  assign tick        = (anim_period != '0) && (tick_cnt == anim_period);
  assign rom_addr    = addr_arr;
  assign rd          = rom_data;
  assign unused_wdata = ^writedata[31:24];

  genvar i;
  generate
    for (i = 0; i < N_SPRITES; i++) begin : g_lane
      sprite_lane #(.SIZE(SIZE), .ADDR_W(ADDR_W)) u_lane (
        .clk         (clk),
        .reset       (reset),
        .wr_x        (spr_wr && address[7:2] == 6'(i) && address[1:0] == 2'd0),
        .wr_y        (spr_wr && address[7:2] == 6'(i) && address[1:0] == 2'd1),
        .wr_ctrl     (spr_wr && address[7:2] == 6'(i) && address[1:0] == 2'd2),
        .wdata       (writedata[9:0]),
        .frame_latch (frame_latch),
        .tick        (tick),
        .px          (px),
        .py          (vcount),
        .rom_addr    (addr_arr[i]),
        .hit_q       (hit_s2[i])
      );
    end
  endgenerate

  // Global registers act immediately; no shadowing.
  always_ff @(posedge clk) begin
    if (reset) begin
      sky         <= 24'h87CEEB;
      ground      <= 24'hFFFFFF;
      line_c      <= 24'h000000;
      horizon     <= 10'd200;
      anim_period <= 24'd5_000_000;
    end else if (wr && address[8]) begin
      case (address[7:0])
        8'd0: sky         <= writedata[23:0];
        8'd1: ground      <= writedata[23:0];
        8'd2: line_c      <= writedata[23:0];
        8'd3: horizon     <= writedata[9:0];
        8'd4: anim_period <= writedata[23:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                              tick_cnt <= '0;
    else if ((wr && address == 9'd260) || tick || anim_period == '0) tick_cnt <= '0;
    else                                                    tick_cnt <= tick_cnt + 24'd1;
  end

  always_comb begin
    if (vcount < horizon)       bg0 = sky;
    else if (vcount == horizon) bg0 = line_c;
    else                        bg0 = ground;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_s1    <= '0;
      bg_s2    <= '0;
      vld_pipe <= '0;
    end else begin
      bg_s1    <= bg0;
      bg_s2    <= bg_s1;
      vld_pipe <= {vld_pipe[STAGES-1:1], blank_n_in};
    end
  end

  // Stage 2 reads the registered ROM output directly; scanning high to low lets
  // the lowest opaque index win.
  always_comb begin
    pix = bg_s2;
    for (int s = N_SPRITES-1; s >= 0; s--)
      if (hit_s2[s] && rd[s] != 16'hF81F && rd[s] != 16'hFFFF)
        pix = {rd[s][15:11], 3'b000, rd[s][10:5], 2'b00, rd[s][4:0], 3'b000};
    if (!vld_pipe[STAGES]) pix = '0;
  end

  assign VGA_R       = pix[23:16];
  assign VGA_G       = pix[15:8];
  assign VGA_B       = pix[7:0];
  assign blank_n_out = vld_pipe[STAGES];
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-slot sprite engine for the dino-run display path. It sits between the `vga_counters` timing generator and the VGA DAC pins, with Avalon-style register writes from the HPS. It composes a three-band background (sky, horizon line, ground) with up to N_SPRITES 16-bit RGB565 sprites, each with its own external ROM. Per-sprite features are enable, horizontal flip, fixed index priority and multi-frame animation. Position and control writes are shadowed and applied once per frame, so the picture never tears.

## Interface
- N_SPRITES, 8: number of sprite slots (1..32)
- SIZE, 32: sprite edge in pixels (power of two)
- X_SHIFT, 1: right-shift applied to hcount to form pixel x (1 for the 1280-count line)
- V_ACTIVE, 480: first non-visible vcount line
- ADDR_W, $clog2(4*SIZE*SIZE): per-sprite ROM address width (up to 4 frames)
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- chipselect  in  1  register-access select
- write  in  1  write strobe; qualified by chipselect
- address  in  9  register address
- writedata  in  32  register data
- hcount  in  11  from vga_counters
- vcount  in  10  from vga_counters
- blank_n_in  in  1  VGA_BLANK_n from vga_counters
- rom_addr  out  N_SPRITES*ADDR_W  sprite i address in slice i
- rom_data  in  N_SPRITES*16  sprite i RGB565; valid 1 cycle after rom_addr (registered ROM)
- VGA_R, VGA_G, VGA_B  out  8 each  composed pixel
- blank_n_out  out  1  blank_n_in delayed to align with RGB

## Operation
- Register map (writes only; unmapped addresses ignored):
  - sprite i at 4i+0: x[9:0]
  - 4i+1: y[9:0]
  - 4i+2: ctrl — bit0 enable, bit1 hflip, bit2 anim_en, bits[4:3] nframes-1
  - 4i+3: reserved
  - 256 sky RGB[23:0]; 257 ground RGB; 258 line RGB; 259 horizon[9:0]; 260 anim_period[23:0]
- Shadowing:
  - Sprite regs (4i+0..2) write shadow copies.
  - Active copy loads from shadow on the cycle where hcount==0 && vcount==V_ACTIVE (frame latch).
  - Global regs (256..260) take effect the next cycle.
- Background: vcount<horizon → sky; vcount==horizon → line; otherwise ground.
- Stage 0, per sprite:
  - px = hcount>>X_SHIFT; py = vcount.
  - hit = enable && px>=x && px<x+SIZE && py>=y && py<y+SIZE. Compute with 11-bit sums; no wrap. Sprites crossing the right or bottom edge clip.
  - col = px-x, inverted to (SIZE-1-col) when hflip; row = py-y.
  - rom_addr = frame*SIZE*SIZE + row*SIZE + col, registered. When no hit, rom_addr holds its last value.
- Stage 1: ROM returns data; the hit flags and background colour ride along in pipeline registers.
- Stage 2, priority mux:
  - The lowest-index sprite with hit && data∉{F81F, FFFF} wins.
  - Output is {R5,000},{G6,00},{B5,000}; otherwise the background colour.
  - If delayed blank_n is 0, RGB is forced to 0.
- Animation:
  - 24-bit tick counter counts 0..anim_period, pulses tick at ==anim_period and restarts. anim_period==0 → no ticks.
  - On tick, each anim_en sprite advances frame = (frame>=nframes-1) ? 0 : frame+1. This also recovers when nframes shrinks below frame.
  - frame is 0 while anim_en=0.
  - A write to 260 clears the tick counter.

## Timing
- Reset values:
  - All outputs 0 (RGB 0, blank_n_out 0, rom_addr 0).
  - All sprite shadow and active regs 0 (disabled); frames 0; tick counter 0.
  - sky 0x87CEEB, ground 0xFFFFFF, line 0x000000, horizon 200, anim_period 5_000_000.
- Latency: hcount/vcount/blank_n_in at cycle T → RGB and blank_n_out registered at T+2. Fixed; no stalls.
- Write and frame latch in the same cycle: active loads the old shadow value; the new value lands at the next frame latch.
- Reset asserted mid-frame: pipeline flushes to 0 next cycle; the first valid pixel appears 2 cycles after reset deasserts.
- Tick and a ctrl write in the same cycle: the frame update uses the active (old) ctrl.

## Test plan
- Reset, then run a full frame with no writes → rows 0..199 = 0x87CEEB, row 200 = 0x000000, rows ≥201 = 0xFFFFFF; blank_n_out lags blank_n_in by exactly 2 cycles.
- Sprite 0 at x=100 y=100 enabled, ROM pixel (0,0)=0x07E0 → pixel (100,100) = (0,252,0) in the frame after latch; an identical write mid-frame has no effect until the next latch.
- Sprites 0 and 3 overlapping at (300,300), both opaque → sprite 0 colour; sprite 0 pixel=0xF81F → sprite 3 colour; both transparent → background.
- hflip=1 on sprite 2 at x=50 → rom_addr col at px=50 is 31, at px=81 is 0; x=620 → columns 620..639 drawn, no wrap to x<20.
- anim_period=3, nframes=3 (ctrl bits[4:3]=2), anim_en → frame sequence 0,1,2,0 advancing every 4 clocks; rom_addr offsets 0, 1024, 2048.
- Reset asserted during an active line → RGB 0 next cycle; all sprites disabled after release.
